// File: rtl/comparator_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
package comparator_pkg;

  // Controller states: waiting, scanning bits MSB-first, one-cycle verdict
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  // One-hot verdict: equal / less-than / greater-than (A relative to B)
  typedef struct packed {
    logic e;
    logic l;
    logic g;
  } cmp_result_t;

  localparam cmp_result_t RES_NONE = 3'b000;
  localparam cmp_result_t RES_EQ   = 3'b100;
  localparam cmp_result_t RES_LT   = 3'b010;
  localparam cmp_result_t RES_GT   = 3'b001;

  // Verdict for the first differing bit pair; exactly one of lt/gt is set there
  function automatic cmp_result_t diff_result(input logic i_lt, input logic i_gt);
    cmp_result_t res;
    res.e = 1'b0;
    res.l = i_lt;
    res.g = i_gt;
    return res;
  endfunction

endpackage

// File: rtl/bit_compare_cell.sv
// Combinational single-bit compare of a against b.
module bit_compare_cell (
  input  logic i_a,
  input  logic i_b,
  output logic o_eq,
  output logic o_lt,
  output logic o_gt
);

  assign o_eq = ~(i_a ^ i_b);
  assign o_lt = ~i_a & i_b;
  assign o_gt = i_a & ~i_b;

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator, MSB-first, one bit per clock.
// Optional build macro EARLY_EXIT_EN: stop scanning at the first differing
// bit. Without it every compare scans all WIDTH bits (fixed latency) while
// the verdict is frozen at the first difference.
module serial_mag_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             E,
  output logic             L,
  output logic             G
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] IDX_MSB = IDXW'(WIDTH - 1);

  cmp_state_t       r_state;
  cmp_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_a_q;
  logic [WIDTH-1:0] r_b_q;
  logic [IDXW-1:0]  r_idx;
  cmp_result_t      r_res;
  logic             r_found;
  logic             r_busy;
  logic             r_done;

  logic w_eq;
  logic w_lt;
  logic w_gt;
  logic w_diff;
  logic w_last;
  logic w_accept;
  logic w_decide;
  logic w_busy_nxt;
  logic w_done_nxt;

  // Single compare cell looks at the bit currently selected by the index
  bit_compare_cell u_cell (
    .i_a  (r_a_q[r_idx]),
    .i_b  (r_b_q[r_idx]),
    .o_eq (w_eq),
    .o_lt (w_lt),
    .o_gt (w_gt)
  );

  assign w_diff   = ~w_eq;
  assign w_last   = (r_idx == {IDXW{1'b0}});
  // start is only honoured when not scanning; DONE accepts for back-to-back use
  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

`ifdef EARLY_EXIT_EN
  assign w_decide = w_diff || w_last;
`else
  assign w_decide = w_last;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SCAN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SCAN: begin
        if (w_decide) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = SCAN;
        end
      end
      DONE: begin
        if (w_accept) begin
          w_state_nxt = SCAN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so busy/done line up with it
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    if (w_state_nxt == SCAN) begin
      w_busy_nxt = 1'b1;
    end else if (w_state_nxt == DONE) begin
      w_done_nxt = 1'b1;
    end else begin
      w_busy_nxt = 1'b0;
      w_done_nxt = 1'b0;
    end
  end

  // Registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Operand capture, bit index walk and verdict accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_q   <= {WIDTH{1'b0}};
      r_b_q   <= {WIDTH{1'b0}};
      r_idx   <= {IDXW{1'b0}};
      r_res   <= RES_NONE;
      r_found <= 1'b0;
    end else if (w_accept) begin
      r_a_q   <= A;
      r_b_q   <= B;
      r_idx   <= IDX_MSB;
      r_res   <= RES_NONE;
      r_found <= 1'b0;
    end else if (r_state == SCAN) begin
      // First difference fixes the verdict; later bits cannot change it
      if (!r_found && w_diff) begin
        r_res   <= diff_result(w_lt, w_gt);
        r_found <= 1'b1;
      end else if (!r_found && w_last) begin
        r_res   <= RES_EQ;
        r_found <= 1'b1;
      end else begin
        r_res   <= r_res;
        r_found <= r_found;
      end
      // Index stops at zero rather than wrapping
      if (!w_last) begin
        r_idx <= r_idx - IDXW'(1);
      end else begin
        r_idx <= r_idx;
      end
    end else begin
      r_a_q   <= r_a_q;
      r_b_q   <= r_b_q;
      r_idx   <= r_idx;
      r_res   <= r_res;
      r_found <= r_found;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign E    = r_res.e;
  assign L    = r_res.l;
  assign G    = r_res.g;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench for serial_mag_comparator (WIDTH=8), both build variants.
module tb_serial_mag_comparator;

  localparam int WIDTH = 8;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A     = '0;
  logic [WIDTH-1:0] B     = '0;
  logic             busy;
  logic             done;
  logic             E;
  logic             L;
  logic             G;

  serial_mag_comparator #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .E     (E),
    .L     (L),
    .G     (G)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] elg;
    int         lat;
    int         t0;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   sim_done = 1'b0;

  localparam logic [2:0] X_EQ = 3'b100;
  localparam logic [2:0] X_LT = 3'b010;
  localparam logic [2:0] X_GT = 3'b001;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // k = number of bits up to and including the first difference (WIDTH if equal)
  function automatic int lat_of(input int k);
`ifdef EARLY_EXIT_EN
    return k + 1;
`else
    return WIDTH + 1;
`endif
  endfunction

  task automatic issue(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] elg, input int k, input bit expect_done);
    exp_t e;
    A     = a;
    B     = b;
    start = 1'b1;
    if (expect_done) begin
      e.elg  = elg;
      e.lat  = lat_of(k);
      e.t0   = cyc;
      e.name = nm;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int i;
    i = 0;
    while (!done && i < 40) begin
      @(negedge clk);
      i++;
    end
    check({nm, " done_seen"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    fork
      // Stimulus
      begin
        // Reset held with start high: everything stays quiet
        rst_n = 1'b0;
        start = 1'b1;
        A = 8'hFF;
        B = 8'h00;
        repeat (4) begin
          @(negedge clk);
          check("reset_outs", {27'd0, busy, done, E, L, G}, 32'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        issue("gt_msb", 8'h80, 8'h7F, X_GT, 1, 1'b1);
        wait_done("gt_msb");
        @(negedge clk);
        check("gt_msb hold", {28'd0, done, E, L, G}, {28'd0, 1'b0, X_GT});

        issue("eq_a5", 8'hA5, 8'hA5, X_EQ, 8, 1'b1);
        wait_done("eq_a5");

        // Back-to-back: second start issued in the DONE cycle
        @(negedge clk);
        issue("lt_b2b", 8'h01, 8'h02, X_LT, 7, 1'b1);
        wait_done("lt_b2b");
        issue("eq_b2b", 8'h03, 8'h03, X_EQ, 8, 1'b1);
        check("b2b no_gap busy", {31'd0, busy}, 32'd1);
        wait_done("eq_b2b");

        // Start mid-scan with different operands must be ignored
        @(negedge clk);
        issue("lt_lsb", 8'h3C, 8'h3D, X_LT, 8, 1'b1);
        @(negedge clk);
        A = 8'hFF;
        B = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("midscan busy", {31'd0, busy}, 32'd1);
        wait_done("lt_lsb");

        @(negedge clk);
        issue("lt_all", 8'h00, 8'hFF, X_LT, 1, 1'b1);
        wait_done("lt_all");

        @(negedge clk);
        issue("gt_lsb", 8'hFF, 8'hFE, X_GT, 8, 1'b1);
        wait_done("gt_lsb");

        // Reset mid-scan: immediate clear, no done pulse
        @(negedge clk);
        issue("aborted", 8'hA5, 8'hA5, X_EQ, 8, 1'b0);
        @(negedge clk);
        check("abort busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort outs_now", {27'd0, busy, done, E, L, G}, 32'd0);
        repeat (3) begin
          @(negedge clk);
          check("abort outs_held", {27'd0, busy, done, E, L, G}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        issue("post_rst", 8'h5A, 8'h4B, X_GT, 4, 1'b1);
        wait_done("post_rst");

        repeat (12) @(negedge clk);
        check("pending_expectations", q.size(), 32'd0);
        sim_done = 1'b1;
      end
      // Monitor: pop an expectation whenever done is presented
      begin
        exp_t e;
        while (!sim_done) begin
          @(negedge clk);
          if (rst_n && done) begin
            if (q.size() == 0) begin
              check("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
              e = q.pop_front();
              check({e.name, " ELG"}, {29'd0, E, L, G}, {29'd0, e.elg});
              check({e.name, " latency"}, cyc - e.t0, e.lat);
            end
          end
        end
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
